// File: rtl/ex_branch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ex_branch_stage                                               |
// | Purpose  : Execute-side 2-entry skid buffer with branch resolution,      |
// |            registered fetch redirect and taken-branch counter.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ex_branch_stage #(
  parameter int BR_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_result,
  input  logic            in_is_equal,
  input  logic            in_is_smaller,
  input  logic            in_a_sign,
  input  logic [31:0]     in_pc,
  input  logic [BR_W-1:0] in_br_op,
  input  logic [15:0]     in_offset,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [31:0]     out_pc,
  output logic            out_taken,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     taken_cnt
);

  localparam logic [BR_W-1:0] C_OP_BEQ  = BR_W'(1);
  localparam logic [BR_W-1:0] C_OP_BNE  = BR_W'(2);
  localparam logic [BR_W-1:0] C_OP_BLTZ = BR_W'(3);
  localparam logic [BR_W-1:0] C_OP_BGEZ = BR_W'(4);
  localparam logic [BR_W-1:0] C_OP_BLTU = BR_W'(5);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_main_result;
  logic [31:0] r_main_pc;
  logic        r_main_taken;
  logic [31:0] r_skid_result;
  logic [31:0] r_skid_pc;
  logic        r_skid_taken;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_taken_cnt;

  logic        w_accept;
  logic        w_present;
  logic        w_taken;
  logic [31:0] w_off_ext;
  logic [31:0] w_target;

  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_present = out_valid && out_ready;

  assign w_off_ext = {{14{in_offset[15]}}, in_offset, 2'b00};
  assign w_target  = in_pc + 32'd4 + w_off_ext;

  always_comb begin
    w_taken = 1'b0;
    case (in_br_op)
      C_OP_BEQ:  w_taken = in_is_equal;
      C_OP_BNE:  w_taken = !in_is_equal;
      C_OP_BLTZ: w_taken = in_a_sign;
      C_OP_BGEZ: w_taken = !in_a_sign;
      C_OP_BLTU: w_taken = in_is_smaller;
      default:   w_taken = 1'b0;
    endcase
  end

  // Buffer control; flush overrides every transition and blocks the redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_EMPTY;
      r_main_result    <= 32'd0;
      r_main_pc        <= 32'd0;
      r_main_taken     <= 1'b0;
      r_skid_result    <= 32'd0;
      r_skid_pc        <= 32'd0;
      r_skid_taken     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_taken_cnt      <= 32'd0;
    end else if (flush) begin
      r_state          <= ST_EMPTY;
      r_redirect_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_result <= in_result;
            r_main_pc     <= in_pc;
            r_main_taken  <= w_taken;
            r_state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_present) begin
            r_skid_result <= in_result;
            r_skid_pc     <= in_pc;
            r_skid_taken  <= w_taken;
            r_state       <= ST_TWO;
          end else if (w_accept && w_present) begin
            r_main_result <= in_result;
            r_main_pc     <= in_pc;
            r_main_taken  <= w_taken;
          end else if (w_present) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_present) begin
            r_main_result <= r_skid_result;
            r_main_pc     <= r_skid_pc;
            r_main_taken  <= r_skid_taken;
            r_state       <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase

      r_redirect_valid <= w_accept && w_taken;
      if (w_accept && w_taken) begin
        r_redirect_pc <= w_target;
        r_taken_cnt   <= r_taken_cnt + 32'd1;
      end
    end
  end

  assign out_result     = r_main_result;
  assign out_pc         = r_main_pc;
  assign out_taken      = r_main_taken;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign taken_cnt      = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_branch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ex_branch_stage                                            |
// | Purpose  : Directed vector bench for ex_branch_stage.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ex_branch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_is_equal;
  logic        in_is_smaller;
  logic        in_a_sign;
  logic [31:0] in_pc;
  logic [2:0]  in_br_op;
  logic [15:0] in_offset;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_pc;
  logic        out_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] taken_cnt;

  ex_branch_stage #(.BR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_is_equal(in_is_equal), .in_is_smaller(in_is_smaller), .in_a_sign(in_a_sign),
    .in_pc(in_pc), .in_br_op(in_br_op), .in_offset(in_offset), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_pc(out_pc), .out_taken(out_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        eq;
    logic        sm;
    logic        sg;
    logic [31:0] pc;
    logic [15:0] off;
    logic [31:0] res;
    logic        exp_taken;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t        vecs [12];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] m_cnt  = 32'd0;
  logic [31:0] m_tgt  = 32'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic drive(input logic [2:0] op, input logic eq, input logic sm, input logic sg,
                       input logic [31:0] pc, input logic [15:0] off, input logic [31:0] res);
    in_valid = 1'b1; in_br_op = op; in_is_equal = eq; in_is_smaller = sm;
    in_a_sign = sg; in_pc = pc; in_offset = off; in_result = res;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 1'b1, 1'b0, 1'b0, 32'h0040_0000, 16'h0003, 32'h11, 1'b1, 32'h0040_0010};
    vecs[1]  = '{3'd1, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 16'h0003, 32'h12, 1'b0, 32'h0};
    vecs[2]  = '{3'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 16'hFFFF, 32'h13, 1'b1, 32'h0000_0000};
    vecs[3]  = '{3'd2, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 16'h0001, 32'h14, 1'b0, 32'h0};
    vecs[4]  = '{3'd3, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 16'h0010, 32'h15, 1'b1, 32'h0000_1044};
    vecs[5]  = '{3'd4, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 16'h0010, 32'h16, 1'b0, 32'h0};
    vecs[6]  = '{3'd4, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 16'h0000, 32'h17, 1'b1, 32'h0000_0000};
    vecs[7]  = '{3'd5, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 16'h8000, 32'h18, 1'b1, 32'hFFFE_2004};
    vecs[8]  = '{3'd5, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 16'h0004, 32'h19, 1'b0, 32'h0};
    vecs[9]  = '{3'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 16'h0004, 32'h1A, 1'b0, 32'h0};
    vecs[10] = '{3'd6, 1'b1, 1'b1, 1'b1, 32'h0000_5000, 16'h0004, 32'h1B, 1'b0, 32'h0};
    vecs[11] = '{3'd7, 1'b0, 1'b1, 1'b1, 32'h0000_6000, 16'h0004, 32'h1C, 1'b0, 32'h0};

    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_is_equal = 1'b0; in_is_smaller = 1'b0;
    in_a_sign = 1'b0; in_pc = '0; in_br_op = '0; in_offset = '0; flush = 1'b0; out_ready = 1'b1;

    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Single-entry vectors with the sink always ready.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].eq, vecs[i].sm, vecs[i].sg, vecs[i].pc, vecs[i].off, vecs[i].res);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (vecs[i].exp_taken) begin
        m_cnt = m_cnt + 32'd1;
        m_tgt = vecs[i].exp_tgt;
      end
      chk("vec_out_valid", out_valid, 1);
      chk("vec_out_result", out_result, vecs[i].res);
      chk("vec_out_pc", out_pc, vecs[i].pc);
      chk("vec_out_taken", out_taken, vecs[i].exp_taken);
      chk("vec_redirect_valid", redirect_valid, vecs[i].exp_taken);
      chk("vec_redirect_pc", redirect_pc, m_tgt);
      chk("vec_taken_cnt", taken_cnt, m_cnt);
      @(posedge clk); #1;
      chk("vec_redirect_drop", redirect_valid, 0);
      chk("vec_drained", out_valid, 0);
    end

    // Back-to-back taken branches.
    @(negedge clk);
    drive(3'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 16'h0002, 32'h21);
    @(posedge clk); #1;
    chk("b2b_first_pc", redirect_pc, 32'h0000_080C);
    @(negedge clk);
    drive(3'd3, 1'b0, 1'b0, 1'b1, 32'h0000_0900, 16'hFFFE, 32'h22);
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_cnt = m_cnt + 32'd2;
    m_tgt = 32'h0000_08FC;
    chk("b2b_second_valid", redirect_valid, 1);
    chk("b2b_second_pc", redirect_pc, m_tgt);
    chk("b2b_second_result", out_result, 32'h22);
    chk("b2b_cnt", taken_cnt, m_cnt);
    @(posedge clk); #1;
    chk("b2b_pulse_end", redirect_valid, 0);

    // Backpressure: results 1..4, sink stalled for the first cycles.
    begin
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
        @(negedge clk);
        out_ready = (cyc >= 4);
        in_br_op  = 3'd0;
        in_valid  = (sent < 4);
        in_result = 32'(sent + 1);
        in_pc     = 32'(sent * 4);
        if (cyc == 2) chk("bp_in_ready_low", in_ready, 0);
        if (cyc == 3) chk("bp_head_held", out_result, 1);
        if (out_valid && out_ready) begin
          chk("bp_order", out_result, 32'(got + 1));
          got++;
        end
        if (in_valid && in_ready) sent++;
        @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      chk("bp_all_drained", 32'(got), 4);
    end
    @(posedge clk); #1;
    chk("bp_empty", out_valid, 0);

    // Flush while holding one entry, colliding with a taken bgez.
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 32'h100, 16'h0, 32'hA);
    @(negedge clk);
    drive(3'd4, 1'b0, 1'b0, 1'b0, 32'h200, 16'h4, 32'hB);
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush1_out_valid", out_valid, 0);
    chk("flush1_no_redirect", redirect_valid, 0);
    chk("flush1_cnt", taken_cnt, m_cnt);

    // Flush in the full state, again with a taken bgez offered.
    @(negedge clk);
    drive(3'd0, 1'b0, 1'b0, 1'b0, 32'h300, 16'h0, 32'hC);
    @(negedge clk);
    drive(3'd0, 1'b0, 1'b0, 1'b0, 32'h304, 16'h0, 32'hD);
    @(negedge clk);
    chk("flush2_full", in_ready, 0);
    drive(3'd4, 1'b0, 1'b0, 1'b0, 32'h308, 16'h4, 32'hE);
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush2_out_valid", out_valid, 0);
    chk("flush2_in_ready", in_ready, 1);
    chk("flush2_no_redirect", redirect_valid, 0);
    chk("flush2_cnt", taken_cnt, m_cnt);
    out_ready = 1'b1;

    // Counter wrap from a preloaded all-ones value.
    @(negedge clk);
    force dut.r_taken_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_taken_cnt;
    chk("wrap_preload", taken_cnt, 32'hFFFF_FFFF);
    drive(3'd5, 1'b0, 1'b1, 1'b0, 32'h400, 16'h1, 32'hF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("wrap_cnt_zero", taken_cnt, 32'd0);
    chk("wrap_redirect_pc", redirect_pc, 32'h0000_0408);

    // Asynchronous reset in the middle of a cycle with live state.
    @(negedge clk);
    drive(3'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 16'h0001, 32'h55);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_result", out_result, 0);
    chk("mid_rst_out_pc", out_pc, 0);
    chk("mid_rst_out_taken", out_taken, 0);
    chk("mid_rst_redirect_valid", redirect_valid, 0);
    chk("mid_rst_redirect_pc", redirect_pc, 0);
    chk("mid_rst_taken_cnt", taken_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_branch_stage.md
# ex_branch_stage

Execute-side buffering and branch-resolution stage that sits directly downstream of the `LuiSlt` comparator/LUI unit in the dynamic pipeline. Each cycle it can accept one execute result (`r`, `is_equal`, `is_smaller`) together with its PC, branch opcode and branch offset. It resolves conditional branches, emits a one-cycle redirect to fetch, and forwards the result toward MEM through a 2-entry skid buffer with valid/ready handshakes. It also keeps a wrap-around count of taken branches.

## Interface
- `BR_W`, default 3: width of the branch opcode field.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream holds a valid execute result.
- `in_ready` output 1: this stage can accept an input this cycle.
- `in_result` input 32: `LuiSlt` output `r`.
- `in_is_equal` input 1: `LuiSlt` output `is_equal` (a == b).
- `in_is_smaller` input 1: `LuiSlt` output `is_smaller` (unsigned a < b).
- `in_a_sign` input 1: bit 31 of operand a.
- `in_pc` input 32: PC of the instruction.
- `in_br_op` input `BR_W`: 000 none, 001 beq, 010 bne, 011 bltz, 100 bgez, 101 bltu, others treated as none.
- `in_offset` input 16: branch immediate in words.
- `flush` input 1: kill all buffered entries (exception from a later stage).
- `out_valid` output 1: head entry valid toward MEM.
- `out_ready` input 1: MEM accepts the head entry.
- `out_result` output 32: result of the head entry.
- `out_pc` output 32: PC of the head entry.
- `out_taken` output 1: the head entry was a taken branch.
- `redirect_valid` output 1: one-cycle pulse requesting a fetch redirect.
- `redirect_pc` output 32: branch target, valid while `redirect_valid` is high.
- `taken_cnt` output 32: number of taken branches accepted since reset.

## Operation
- Accept occurs when `in_valid && in_ready && !flush`. Present occurs when `out_valid && out_ready`.
- Taken condition, evaluated at accept:
  - beq: `is_equal`
  - bne: `!is_equal`
  - bltz: `a_sign`
  - bgez: `!a_sign`
  - bltu: `is_smaller`
  - none: 0
- Target is `in_pc + 4 + ({{14{off[15]}}, off, 2'b00})`, computed modulo 2^32; overflow wraps silently.
- Buffer FSM has three states: EMPTY, ONE (main entry only), TWO (main plus skid).
  - EMPTY: on accept, go to ONE.
  - ONE: accept without present goes to TWO (new entry written to skid). Accept with present stays ONE (new entry replaces main). Present without accept goes to EMPTY.
  - TWO: present moves skid into main and goes to ONE. Accept is impossible because `in_ready` = 0.
- `in_ready` = (state != TWO). It is derived from registered state only and has no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY). `out_*` always reflect the main entry.
- `flush` has priority over everything:
  - Next state is EMPTY.
  - An input offered in the same cycle is dropped.
  - A redirect that would be generated this cycle is suppressed.
  - `taken_cnt` is not incremented.
- `redirect_valid` is registered: it goes high the cycle after a taken-branch accept and lasts exactly one cycle. `redirect_pc` holds that target and keeps its value when `redirect_valid` is low.
- The stage does not squash younger instructions; upstream discards them on `redirect_valid`. Delay-slot handling is upstream's responsibility.
- `taken_cnt` increments by 1 on each taken accept and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - state EMPTY, so `in_ready` = 1 and `out_valid` = 0.
  - `out_result`, `out_pc` = 0; `out_taken` = 0.
  - `redirect_valid` = 0; `redirect_pc` = 0.
  - `taken_cnt` = 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: an input accepted at edge N appears on `out_*` and sets `redirect_valid` after edge N (available in cycle N+1). No combinational path exists from `in_*` to any output.
- Throughput: one entry per cycle while `out_ready` = 1.
- After `out_ready` drops: at most one further accept (into skid), then `in_ready` = 0 starting the following cycle.
- Entries leave in strict accept order. No duplication, no loss except through `flush`.
- Back-to-back taken branches produce back-to-back redirect pulses, each carrying its own target.

## Test plan
- Reset then idle: `rst_n` low mid-cycle → all outputs at reset values immediately. After release: `in_ready` = 1, `out_valid` = 0.
- beq taken: pc 0x00400000, off 0x0003, `is_equal` = 1 → next cycle `redirect_valid` = 1, `redirect_pc` = 0x00400010, `out_taken` = 1, `taken_cnt` = 1. The cycle after, `redirect_valid` = 0.
- Backward bne plus wrap: pc 0x00000000, off 0xFFFF, `is_equal` = 0 → `redirect_pc` = 0x00000000. Also with pc 0xFFFFFFFC, off 0 → target 0x00000000.
- Backpressure: stream results 1,2,3,4 with `out_ready` low from cycle 1 → `in_ready` low after two accepts. Raising `out_ready` drains 1,2 then 3,4 in order with none lost.
- Flush collision: state TWO, `flush` = 1 together with `in_valid` on a taken bgez (`a_sign` = 0) → next cycle EMPTY, no redirect, `taken_cnt` unchanged.
- Counter wrap: preload via 2^32−1 taken accepts (or force) → next taken accept gives `taken_cnt` = 0.
